// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle cpu core and its PC sequencer.
package cpu_pkg;
   localparam int          DEF_ADDR_W   = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0028;

   typedef enum logic [2:0] {
      PCS_IDLE,
      PCS_SETTLE,
      PCS_COMMIT,
      PCS_STEP_WAIT,
      PCS_HALTED
   } pcs_state_t;

   localparam logic [1:0] HC_EXT   = 2'd0;
   localparam logic [1:0] HC_LOOP  = 2'd1;
   localparam logic [1:0] HC_BP    = 2'd2;
   localparam logic [1:0] HC_LIMIT = 2'd3;
endpackage

// File: rtl/settle_counter.sv
// 4-bit loadable down-counter; done_o is high whenever the count has reached zero.
module settle_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic       done_o
);
   logic [3:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != 4'd0)) begin
         count_q <= count_q - 4'd1;
      end
   end

   assign done_o = (count_q == 4'd0);
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter driver for the cpu core: holds addr for a settle window, then
// captures the core's next address, with run/halt, single-step and halt detection.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int                ADDR_W        = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC      = ADDR_W'(DEF_RESET_PC),
   parameter int                SETTLE_CYCLES = 1,
   parameter logic [15:0]       MAX_INSTR     = 16'd1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              step_mode,
   input  logic              step,
   input  logic              halt_req,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic [ADDR_W-1:0] next_addr,
   output logic [ADDR_W-1:0] addr,
   output logic              commit,
   output logic              busy,
   output logic              halted,
   output logic [1:0]        halt_cause,
   output logic [15:0]       instr_count
);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   pcs_state_t        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              commit_q;
   logic              busy_q;
   logic              halted_q;
   logic [1:0]        halt_cause_q;
   logic [15:0]       instr_count_q;
   logic              halt_pend_q;
   logic              bp_skip_q;

   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_done;
   logic              hit_ext;
   logic              hit_loop;
   logic              hit_bp;
   logic              hit_limit;
   logic              halt_any;
   logic [1:0]        cause_d;
   logic [15:0]       instr_count_d;

   settle_counter u_settle (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (cnt_load),
      .load_val_i (SETTLE_LOAD),
      .dec_i      (cnt_dec),
      .done_o     (cnt_done)
   );

   always_comb begin
      hit_ext       = halt_req || halt_pend_q;
      hit_loop      = (next_addr == addr_q);
      // bp_skip_q lets the instruction after a resume run past the breakpoint.
      hit_bp        = bp_en && !bp_skip_q && (next_addr == bp_addr);
      hit_limit     = (({1'b0, instr_count_q} + 17'd1) == {1'b0, MAX_INSTR});
      halt_any      = hit_ext || hit_loop || hit_bp || hit_limit;
      cause_d       = hit_ext  ? HC_EXT  :
                      hit_loop ? HC_LOOP :
                      hit_bp   ? HC_BP   : HC_LIMIT;
      instr_count_d = (instr_count_q == 16'hFFFF) ? instr_count_q : instr_count_q + 16'd1;
      cnt_dec       = (state_q == PCS_SETTLE);
      cnt_load      = 1'b0;
      case (state_q)
         PCS_IDLE:      cnt_load = start;
         PCS_COMMIT:    cnt_load = !halt_any && !step_mode;
         PCS_STEP_WAIT: cnt_load = step && !halt_req;
         PCS_HALTED:    cnt_load = start;
         default:       cnt_load = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= PCS_IDLE;
         addr_q        <= RESET_PC;
         commit_q      <= 1'b0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         halt_cause_q  <= HC_EXT;
         instr_count_q <= '0;
         halt_pend_q   <= 1'b0;
         bp_skip_q     <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         case (state_q)
            PCS_IDLE: begin
               if (start) begin
                  state_q <= PCS_SETTLE;
                  busy_q  <= 1'b1;
               end
            end
            PCS_SETTLE: begin
               if (halt_req) halt_pend_q <= 1'b1;
               if (cnt_done) state_q <= PCS_COMMIT;
            end
            PCS_COMMIT: begin
               addr_q        <= next_addr;
               instr_count_q <= instr_count_d;
               commit_q      <= 1'b1;
               bp_skip_q     <= 1'b0;
               if (halt_any) begin
                  state_q      <= PCS_HALTED;
                  busy_q       <= 1'b0;
                  halted_q     <= 1'b1;
                  halt_cause_q <= cause_d;
                  halt_pend_q  <= 1'b0;
               end else if (step_mode) begin
                  state_q <= PCS_STEP_WAIT;
               end else begin
                  state_q <= PCS_SETTLE;
               end
            end
            PCS_STEP_WAIT: begin
               if (halt_req) begin
                  state_q      <= PCS_HALTED;
                  busy_q       <= 1'b0;
                  halted_q     <= 1'b1;
                  halt_cause_q <= HC_EXT;
               end else if (step) begin
                  state_q <= PCS_SETTLE;
               end
            end
            PCS_HALTED: begin
               if (start) begin
                  state_q      <= PCS_SETTLE;
                  busy_q       <= 1'b1;
                  halted_q     <= 1'b0;
                  halt_cause_q <= HC_EXT;
                  bp_skip_q    <= 1'b1;
               end
            end
            default: state_q <= PCS_IDLE;
         endcase
      end
   end

   assign addr        = addr_q;
   assign commit      = commit_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign halt_cause  = halt_cause_q;
   assign instr_count = instr_count_q;
endmodule
